down_timer: RTL and testbench

Programmable down-counting timer, the counting-down complement of the free-running up counter in the practical set. It is loaded with a reload value, started, and decrements once per enabled clock to zero, emitting a one-cycle `done` pulse at terminal count. It supports one-shot and auto-reload modes, pause and stop, and serves as a delay/period generator for downstream sequencing logic.

---
 rtl/down_timer_pkg.sv | 12 +
 rtl/down_timer_if.sv | 30 +++
 rtl/down_timer.sv | 89 ++++++++
 tb/tb_down_timer.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/down_timer_pkg.sv
// Shared types and constants for the down-counting timer.
package timer_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_e;

endpackage

// File: rtl/down_timer_if.sv
// Control/status bundle between a sequencer and the down timer.
interface down_timer_if
  import timer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             stop;
  logic             pause;
  logic             auto_reload;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;

  modport master (
    output load, load_val, start, stop,
    output pause, auto_reload,
    input  count, busy, done
  );

  modport slave (
    input  load, load_val, start, stop,
    input  pause, auto_reload,
    output count, busy, done
  );

endinterface

// File: rtl/down_timer.sv
// Programmable down timer: one-shot or auto-reload,
// with pause/stop and a registered one-cycle done pulse.
module down_timer
  import timer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic         clk,
  input  logic         reset,
  down_timer_if.slave  bus
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] rld_q, rld_d;
  logic             mode_q, mode_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] v;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      rld_q   <= '0;
      mode_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rld_q   <= rld_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    rld_d   = bus.load ? bus.load_val : rld_q;
    v       = bus.load ? bus.load_val : rld_q;

    if (bus.stop) begin
      state_d = IDLE;
    end else if (bus.start) begin
      if (v != '0) begin
        count_d = v;
        mode_d  = bus.auto_reload;
        state_d = RUN;
      end else begin
        count_d = '0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
    end else if (state_q == RUN && bus.pause) begin
      state_d = PAUSED;
    end else if (state_q == PAUSED && bus.pause) begin
      state_d = PAUSED;
    end else if (state_q != IDLE) begin
      // Leaving PAUSED counts on the same edge so each
      // paused cycle costs exactly one cycle.
      state_d = RUN;
      if (count_q > ONE) begin
        count_d = count_q - ONE;
      end else begin
        done_d = 1'b1;
        if (mode_q && rld_q != '0) begin
          count_d = rld_q;
        end else begin
          count_d = '0;
          state_d = IDLE;
        end
      end
    end

    busy_d = (state_d != IDLE);
  end

  assign bus.count = count_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_down_timer.sv
// Directed self-checking bench for down_timer.
module tb_down_timer;

  localparam int W = 4;

  logic clk;
  logic reset;
  int   n_run;
  int   n_fail;

  down_timer_if #(.WIDTH(W)) bus ();

  down_timer #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs,
                       input int exp);
    n_run++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect3(input string tag, input int c,
                         input int b, input int d);
    check({tag, ".count"}, int'(bus.count), c);
    check({tag, ".busy"}, int'(bus.busy), b);
    check({tag, ".done"}, int'(bus.done), d);
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    bus.load        = 1'b0;
    bus.load_val    = '0;
    bus.start       = 1'b0;
    bus.stop        = 1'b0;
    bus.pause       = 1'b0;
    bus.auto_reload = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    expect3("reset", 0, 0, 0);
    reset = 1'b0;

    // one-shot from 5
    bus.load = 1'b1; bus.load_val = 4'd5;
    tick();
    bus.load = 1'b0;
    expect3("ld5", 0, 0, 0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    expect3("os_e0", 5, 1, 0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      expect3($sformatf("os_e%0d", k), 5 - k, 1, 0);
    end
    tick();
    expect3("os_term", 0, 0, 1);
    tick();
    expect3("os_after", 0, 0, 0);

    // auto-reload period 3
    bus.load = 1'b1; bus.load_val = 4'd3;
    tick();
    bus.load = 1'b0;
    bus.start = 1'b1; bus.auto_reload = 1'b1;
    tick();
    bus.start = 1'b0; bus.auto_reload = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) tick();
      expect3($sformatf("ar_e%0d", k), 3 - (k % 3), 1,
              (k > 0 && k % 3 == 0) ? 1 : 0);
    end
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    expect3("ar_stop", 3, 0, 0);

    // one-shot 6 with 4 paused cycles at count 4
    bus.load = 1'b1; bus.load_val = 4'd6; bus.start = 1'b1;
    tick();
    bus.load = 1'b0; bus.start = 1'b0;
    expect3("ps_e0", 6, 1, 0);
    tick();
    tick();
    expect3("ps_e2", 4, 1, 0);
    bus.pause = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      expect3($sformatf("ps_hold%0d", k), 4, 1, 0);
    end
    bus.pause = 1'b0;
    for (int k = 3; k >= 1; k--) begin
      tick();
      expect3($sformatf("ps_cnt%0d", k), k, 1, 0);
    end
    tick();
    expect3("ps_term", 0, 0, 1);

    // stop at 2, then start+load 9 together
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    expect3("st_e0", 6, 1, 0);
    for (int k = 0; k < 4; k++) tick();
    expect3("st_at2", 2, 1, 0);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    expect3("st_stop", 2, 0, 0);
    tick();
    expect3("st_idle", 2, 0, 0);
    bus.start = 1'b1; bus.load = 1'b1; bus.load_val = 4'd9;
    tick();
    bus.start = 1'b0; bus.load = 1'b0;
    expect3("st_ld9", 9, 1, 0);
    tick();
    expect3("st_dec", 8, 1, 0);

    // zero reload with auto-reload: single pulse
    bus.load = 1'b1; bus.load_val = 4'd0;
    tick();
    bus.load = 1'b0;
    bus.start = 1'b1; bus.auto_reload = 1'b1;
    tick();
    bus.start = 1'b0; bus.auto_reload = 1'b0;
    expect3("z_pulse", 0, 0, 1);
    tick();
    expect3("z_norpt", 0, 0, 0);

    // async reset mid auto-reload at count 2
    bus.load = 1'b1; bus.load_val = 4'd4;
    bus.start = 1'b1; bus.auto_reload = 1'b1;
    tick();
    bus.load = 1'b0; bus.start = 1'b0; bus.auto_reload = 1'b0;
    tick();
    tick();
    expect3("rs_pre", 2, 1, 0);
    #2;
    reset = 1'b1;
    #1;
    expect3("rs_async", 0, 0, 0);
    #1;
    reset = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    expect3("rs_rld0", 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
